// File: rtl/serial_adder_n_if.sv
// Handshake and operand bundle for the bit-serial adder.
// The master drives a request; the slave returns result and status.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop,
// operands consumed LSB-first over WIDTH cycles.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  serial_adder_n_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic             c_nxt;
  logic             s;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign accept = bus.start &&
                  (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(WIDTH - 1));

  assign s     = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_nxt = (a_sr[0] & b_sr[0]) |
                 (a_sr[0] & carry) |
                 (b_sr[0] & carry);

  always_comb begin
    res_nxt            = res_sr >> 1;
    res_nxt[WIDTH-1]   = s;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sr  <= bus.a;
      b_sr  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub | bus.cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      carry  <= c_nxt;
      cnt    <= cnt + 1'b1;
      // carry still holds the carry into the MSB here
      if (last) begin
        sum_q  <= res_nxt;
        cout_q <= c_nxt;
        ovf_q  <= carry ^ c_nxt;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule
